speed_ramp_ctrl: RTL and testbench
==================================

SPEED_RAMP_CTRL -- requirements
Module: speed_ramp_ctrl

Interface
REQ-001 SHALL have parameter RAMP_STEP, default 10, max |speed| change per ramp tick (400rpm units).
REQ-002 SHALL have parameter TICK_DIV, default 50000, clocks per ramp tick.
REQ-003 SHALL have parameter DWELL_TICKS, default 100, ramp ticks held at zero before direction reversal.
REQ-004 SHALL have parameter STALL_TICKS, default 500, consecutive stalled ticks before fault.
REQ-005 SHALL have parameter SPEED_MAX, default 2000, magnitude clamp on accepted target.
REQ-006 SHALL have parameter PERIOD_MAX, default 32'h7fffffff, encoder period value meaning "no motion".
REQ-007 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-008 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-009 SHALL have port target_speed  in  32 signed [0:31]  commanded speed.
REQ-010 SHALL have port target_valid  in  1  one-cycle strobe latching target_speed.
REQ-011 SHALL have port period  in  32 signed [0:31]  measured encoder period.
REQ-012 SHALL have port fault_clear  in  1  one-cycle strobe leaving STALL.
REQ-013 SHALL have port speed_400rpm  out  32 signed [0:31]  registered ramped speed, feeds the speed-to-duty datapath.
REQ-014 SHALL have port busy  out  1  high whenever state != HOLD.
REQ-015 SHALL have port stall_fault  out  1  registered, high in STALL.

Function
REQ-016 SHALL run a tick counter 0..TICK_DIV-1; tick_en is high in the cycle the counter equals TICK_DIV-1, then counter wraps to 0.
REQ-017 SHALL latch target_valid data into target register, clamped to [-SPEED_MAX, +SPEED_MAX], in any state except STALL; ignored in STALL.
REQ-018 SHALL implement states HOLD, RAMP, DWELL, STALL.
REQ-019 HOLD: when target != speed_400rpm, SHALL go to RAMP next cycle; speed unchanged.
REQ-020 RAMP, on tick_en, if speed_400rpm != 0 and sign differs from target (target nonzero): SHALL move speed toward 0 by RAMP_STEP, saturating at 0; on reaching 0 SHALL enter DWELL with dwell counter cleared.
REQ-021 RAMP, on tick_en, otherwise: SHALL move speed toward target by min(RAMP_STEP, |target-speed|); when equal SHALL enter HOLD in the same update.
REQ-022 RAMP with target already equal to speed (target changed back mid-ramp) SHALL enter HOLD on next tick_en without speed change.
REQ-023 DWELL: speed held 0; dwell counter SHALL increment on each tick_en; after DWELL_TICKS ticks SHALL enter RAMP; if target becomes 0 during DWELL SHALL enter HOLD next cycle.
REQ-024 Ramp arithmetic SHALL use 33-bit signed intermediates; output never exceeds target in magnitude, no overshoot.
REQ-025 speed_400rpm SHALL change only on tick_en edges, except forced to 0 on STALL entry.
REQ-026 Stall counter SHALL increment on tick_en when period == PERIOD_MAX and speed_400rpm != 0, clear to 0 on any tick_en where the condition is false, saturate at STALL_TICKS.
REQ-027 On stall counter reaching STALL_TICKS SHALL enter STALL from any state next cycle: speed_400rpm=0, stall_fault=1.
REQ-028 STALL: on fault_clear SHALL set target=0, clear stall counter, stall_fault=0, enter HOLD next cycle; fault_clear outside STALL has no effect.
REQ-029 fault_clear and target_valid in same cycle in STALL: fault_clear wins, target=0.

Reset
REQ-030 On reset_n=0 at clk edge SHALL set speed_400rpm=0, target=0, state=HOLD, busy=0, stall_fault=0, all counters=0, regardless of state (incl. mid-ramp, STALL).

Configuration
REQ-031 Macro SPEED_RAMP_STALL_DETECT_EN defined: stall counter and STALL state present per REQ-026..029.
REQ-032 Macro undefined: no stall logic, stall_fault tied 0, period and fault_clear ignored, STALL unreachable.

Verification (RAMP_STEP=10, TICK_DIV=4, DWELL_TICKS=3, STALL_TICKS=5, SPEED_MAX=2000)
REQ-033 From reset, target 35 -> speed 10,20,30,35 on consecutive ticks (4 clocks apart), busy falls with the 35 update.
REQ-034 At 35, target -25 -> 25,15,5,0, then 0 for 3 ticks, then -10,-20,-25, HOLD.
REQ-035 At 35, period=PERIOD_MAX for 5 ticks -> stall_fault=1, speed 0; target_valid 100 ignored; fault_clear -> HOLD, speed stays 0.
REQ-036 Period=PERIOD_MAX 4 ticks then normal 1 tick then max 4 ticks -> no fault; target 5000 -> clamped, speed ramps to 2000.
REQ-037 reset_n low mid-ramp at speed 20 -> next edge all outputs 0, state HOLD.
REQ-038 Macro undefined: period=PERIOD_MAX 100 ticks at speed 35 -> stall_fault stays 0, speed stays 35.

Source files
------------

// File: rtl/speed_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : speed_ramp_ctrl
// Purpose  : Rate-limited speed command generator. Ramps a registered speed
//            toward a clamped target once per ramp tick, dwells at zero
//            before reversing direction, and optionally detects a stalled
//            rotor from the encoder period.
// Options  : `define SPEED_RAMP_STALL_DETECT_EN to build the stall counter and
//            the STALL state. Without it, period and fault_clear are unused
//            and stall_fault is held at 0.
// Revision : 1.0 - initial release
// ============================================================================
module speed_ramp_ctrl #(
  parameter int                 RAMP_STEP   = 10,
  parameter int                 TICK_DIV    = 50000,
  parameter int                 DWELL_TICKS = 100,
  parameter int                 STALL_TICKS = 500,
  parameter int                 SPEED_MAX   = 2000,
  parameter logic signed [31:0] PERIOD_MAX  = 32'sh7fffffff
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [31:0] target_speed,
  input  logic               target_valid,
  input  logic signed [31:0] period,
  input  logic               fault_clear,
  output logic signed [31:0] speed_400rpm,
  output logic               busy,
  output logic               stall_fault
);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RAMP  = 2'd1,
    DWELL = 2'd2,
    STALL = 2'd3
  } state_t;

  localparam logic [31:0]        TICK_LAST  = 32'(TICK_DIV - 1);
  localparam logic [31:0]        DWELL_LAST = 32'(DWELL_TICKS - 1);
  localparam logic signed [31:0] SPD_MAX    = 32'(SPEED_MAX);
  localparam logic signed [32:0] STEP       = 33'(RAMP_STEP);

  state_t             state;
  logic signed [31:0] target;
  logic [31:0]        tick_cnt;
  logic [31:0]        dwell_cnt;
  logic               tick_en;
  logic               stall_enter;

  // Ramp datapath intermediates, one bit wider than the speed so that
  // target-minus-speed can never wrap.
  logic signed [32:0] spd_ext;
  logic signed [32:0] tgt_ext;
  logic signed [32:0] diff;
  logic signed [32:0] diff_mag;
  logic signed [32:0] spd_mag;
  logic signed [31:0] next_zero;
  logic signed [31:0] next_tgt;
  logic signed [31:0] clamped;
  logic               reversing;

  // Free-running ramp tick divider.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick_en) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
    end
  end

  assign tick_en = (tick_cnt == TICK_LAST);

  // Candidate next speeds and the clamped incoming target.
  always_comb begin
    spd_ext   = {speed_400rpm[31], speed_400rpm};
    tgt_ext   = {target[31], target};
    diff      = tgt_ext - spd_ext;
    diff_mag  = diff[32] ? -diff : diff;
    spd_mag   = spd_ext[32] ? -spd_ext : spd_ext;
    next_zero = spd_ext[32] ? 32'(spd_ext + STEP) : 32'(spd_ext - STEP);
    next_tgt  = diff[32] ? 32'(spd_ext - STEP) : 32'(spd_ext + STEP);
    reversing = (speed_400rpm != '0) && (target != '0) &&
                (speed_400rpm[31] != target[31]);
    if (target_speed > SPD_MAX) begin
      clamped = SPD_MAX;
    end else if (target_speed < -SPD_MAX) begin
      clamped = -SPD_MAX;
    end else begin
      clamped = target_speed;
    end
  end

`ifdef SPEED_RAMP_STALL_DETECT_EN
  localparam logic [31:0] STALL_LAST = 32'(STALL_TICKS);

  logic [31:0] stall_cnt;

  // Count consecutive ticks with a moving command but no encoder motion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (state == STALL && fault_clear) begin
      stall_cnt <= '0;
    end else if (tick_en) begin
      if (period == PERIOD_MAX && speed_400rpm != '0) begin
        if (stall_cnt != STALL_LAST) begin
          stall_cnt <= stall_cnt + 32'd1;
        end
      end else begin
        stall_cnt <= '0;
      end
    end
  end

  assign stall_enter = (state != STALL) && (stall_cnt == STALL_LAST);
`else
  logic unused_inputs;

  assign unused_inputs = ^{period, fault_clear, PERIOD_MAX, 32'(STALL_TICKS)};
  assign stall_enter   = 1'b0;
  assign stall_fault   = 1'b0;
`endif

  // Ramp state machine with registered speed, target and status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= HOLD;
      speed_400rpm <= '0;
      target       <= '0;
      dwell_cnt    <= '0;
      busy         <= 1'b0;
`ifdef SPEED_RAMP_STALL_DETECT_EN
      stall_fault  <= 1'b0;
`endif
    end else begin
      if (target_valid && state != STALL) begin
        target <= clamped;
      end

      if (stall_enter) begin
        state        <= STALL;
        speed_400rpm <= '0;
        busy         <= 1'b1;
`ifdef SPEED_RAMP_STALL_DETECT_EN
        stall_fault  <= 1'b1;
`endif
      end else begin
        case (state)
          HOLD: begin
            if (target != speed_400rpm) begin
              state <= RAMP;
              busy  <= 1'b1;
            end
          end

          RAMP: begin
            if (tick_en) begin
              if (reversing) begin
                // Decelerate to zero first; the dwell precedes reversal.
                if (spd_mag <= STEP) begin
                  speed_400rpm <= '0;
                  state        <= DWELL;
                  dwell_cnt    <= '0;
                end else begin
                  speed_400rpm <= next_zero;
                end
              end else if (diff_mag <= STEP) begin
                // Final partial step lands exactly on target (no overshoot).
                speed_400rpm <= target;
                state        <= HOLD;
                busy         <= 1'b0;
              end else begin
                speed_400rpm <= next_tgt;
              end
            end
          end

          DWELL: begin
            if (target == '0) begin
              state     <= HOLD;
              busy      <= 1'b0;
              dwell_cnt <= '0;
            end else if (tick_en) begin
              if (dwell_cnt == DWELL_LAST) begin
                state     <= RAMP;
                dwell_cnt <= '0;
              end else begin
                dwell_cnt <= dwell_cnt + 32'd1;
              end
            end
          end

          STALL: begin
`ifdef SPEED_RAMP_STALL_DETECT_EN
            if (fault_clear) begin
              target      <= '0;
              state       <= HOLD;
              busy        <= 1'b0;
              stall_fault <= 1'b0;
            end
`else
            state <= HOLD;
            busy  <= 1'b0;
`endif
          end

          default: begin
            state <= HOLD;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_speed_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_speed_ramp_ctrl
// Purpose  : Directed, table-driven bench for speed_ramp_ctrl with
//            RAMP_STEP=10, TICK_DIV=4, DWELL_TICKS=3, STALL_TICKS=5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_speed_ramp_ctrl;

  localparam int                 TDIV  = 4;
  localparam logic signed [31:0] PMAX  = 32'sh7fffffff;
  localparam logic signed [31:0] PNORM = 32'sd1000;

  logic               clk = 1'b0;
  logic               reset_n;
  logic signed [31:0] target_speed;
  logic               target_valid;
  logic signed [31:0] period;
  logic               fault_clear;
  logic signed [31:0] speed_400rpm;
  logic               busy;
  logic               stall_fault;

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;

  typedef struct {
    bit tv;
    int tgt;
    int n;
    int exp_spd;
    bit exp_busy;
  } vec_t;

  vec_t vecs[$];

  speed_ramp_ctrl #(
    .RAMP_STEP  (10),
    .TICK_DIV   (TDIV),
    .DWELL_TICKS(3),
    .STALL_TICKS(5),
    .SPEED_MAX  (2000),
    .PERIOD_MAX (PMAX)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .target_speed(target_speed),
    .target_valid(target_valid),
    .period      (period),
    .fault_clear (fault_clear),
    .speed_400rpm(speed_400rpm),
    .busy        (busy),
    .stall_fault (stall_fault)
  );

  always #5 clk = ~clk;

  // Edges since reset release; every TDIV-th edge is a ramp tick edge.
  always @(posedge clk) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_tick();
    int guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while ((edges % TDIV) != 0 && guard < 2 * TDIV);
  endtask

  task automatic strobe_target(input int v, input bit with_clear);
    target_speed = v;
    target_valid = 1'b1;
    fault_clear  = with_clear;
    @(posedge clk);
    #1;
    target_valid = 1'b0;
    fault_clear  = 1'b0;
  endtask

  task automatic check_outs(input string name, input int spd, input bit bsy,
                            input bit flt);
    chk({name, " speed"}, speed_400rpm, spd);
    chk({name, " busy"}, {31'd0, busy}, {31'd0, bsy});
    chk({name, " stall_fault"}, {31'd0, stall_fault}, {31'd0, flt});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n      = 1'b0;
    target_speed = '0;
    target_valid = 1'b0;
    period       = PNORM;
    fault_clear  = 1'b0;

    // Directed vectors: {strobe, target, ticks to advance, speed, busy}.
    vecs.push_back('{1, 35, 1, 10, 1});
    vecs.push_back('{0, 0, 1, 20, 1});
    vecs.push_back('{0, 0, 1, 30, 1});
    vecs.push_back('{0, 0, 1, 35, 0});
    vecs.push_back('{1, -25, 1, 25, 1});
    vecs.push_back('{0, 0, 1, 15, 1});
    vecs.push_back('{0, 0, 1, 5, 1});
    vecs.push_back('{0, 0, 1, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 1});
    vecs.push_back('{0, 0, 1, 0, 1});
    vecs.push_back('{0, 0, 1, -10, 1});
    vecs.push_back('{0, 0, 1, -20, 1});
    vecs.push_back('{0, 0, 1, -25, 0});
    vecs.push_back('{1, 0, 1, -15, 1});
    vecs.push_back('{0, 0, 1, -5, 1});
    vecs.push_back('{0, 0, 1, 0, 0});
    vecs.push_back('{1, 35, 4, 35, 0});
    vecs.push_back('{1, 55, 1, 45, 1});
    vecs.push_back('{1, 45, 1, 45, 0});
    vecs.push_back('{1, -25, 5, 0, 1});
    vecs.push_back('{1, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 2, 0, 0});

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 0, 1'b0, 1'b0);

    reset_n = 1'b1;
    next_tick();
    check_outs("idle", 0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      if (vecs[i].tv) strobe_target(vecs[i].tgt, 1'b0);
      repeat (vecs[i].n) next_tick();
      check_outs($sformatf("vec%0d", i), vecs[i].exp_spd, vecs[i].exp_busy, 1'b0);
    end

    // Positive clamp: 5000 becomes 2000, reached in 200 ticks.
    strobe_target(5000, 1'b0);
    for (int k = 1; k <= 200; k++) begin
      next_tick();
      chk($sformatf("clamp_pos tick%0d speed", k), speed_400rpm, 10 * k);
    end
    chk("clamp_pos busy", {31'd0, busy}, 32'd0);

    // Negative clamp with reversal: down to 0, dwell 3 ticks, up to -2000.
    strobe_target(-5000, 1'b0);
    for (int k = 1; k <= 403; k++) begin
      int e;
      next_tick();
      if (k <= 200)      e = 2000 - 10 * k;
      else if (k <= 203) e = 0;
      else               e = -10 * (k - 203);
      chk($sformatf("clamp_neg tick%0d speed", k), speed_400rpm, e);
    end
    chk("clamp_neg busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a ramp clears outputs and the target.
    strobe_target(0, 1'b0);
    repeat (201) next_tick();
    check_outs("to_zero", 0, 1'b0, 1'b0);
    strobe_target(35, 1'b0);
    repeat (2) next_tick();
    chk("midramp speed", speed_400rpm, 20);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_outs("midramp_reset", 0, 1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (2) next_tick();
    check_outs("after_reset", 0, 1'b0, 1'b0);

    strobe_target(35, 1'b0);
    repeat (4) next_tick();
    check_outs("at35", 35, 1'b0, 1'b0);

`ifdef SPEED_RAMP_STALL_DETECT_EN
    // Five stalled ticks, then STALL one cycle later.
    period = PMAX;
    repeat (5) next_tick();
    check_outs("pre_stall", 35, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outs("stall", 0, 1'b1, 1'b1);
    strobe_target(100, 1'b0);
    repeat (2) next_tick();
    check_outs("stall_ignore_tv", 0, 1'b1, 1'b1);
    period = PNORM;
    strobe_target(100, 1'b1);
    check_outs("stall_clear", 0, 1'b0, 1'b0);
    repeat (2) next_tick();
    check_outs("cleared_target0", 0, 1'b0, 1'b0);

    // Interrupted stall pattern must not fault.
    strobe_target(35, 1'b0);
    repeat (4) next_tick();
    check_outs("at35_b", 35, 1'b0, 1'b0);
    period = PMAX;
    repeat (4) next_tick();
    period = PNORM;
    next_tick();
    period = PMAX;
    repeat (4) next_tick();
    @(posedge clk);
    #1;
    check_outs("no_stall", 35, 1'b0, 1'b0);
    period = PNORM;
`else
    // Without stall detection the stalled encoder has no effect.
    period = PMAX;
    for (int k = 1; k <= 100; k++) begin
      next_tick();
      chk($sformatf("nostall tick%0d speed", k), speed_400rpm, 35);
      chk($sformatf("nostall tick%0d stall_fault", k), {31'd0, stall_fault}, 32'd0);
    end
    strobe_target(35, 1'b1);
    next_tick();
    check_outs("nostall_clear", 35, 1'b0, 1'b0);
    period = PNORM;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
